// File: rtl/deserializer_ni.sv
// Ejection-side NI stage: reassembles typed flits into one wide message and hands it
// to the consumer over a valid/ready handshake. Define DESERIALIZER_NI_ERR_CNT_EN to build the error counter.
module deserializer_ni #(
  parameter int FLIT_SIZE      = 64,
  parameter int FLIT_TYPE_SIZE = 2,
  parameter int OUTPUT_WIDTH   = 256
) (
  input  logic                      clk,
  input  logic                      rst_p,
  input  logic                      req_in,
  input  logic [FLIT_SIZE-1:0]      data_in,
  input  logic [FLIT_TYPE_SIZE-1:0] data_type_in,
  input  logic                      BroadcastL2_VN0_in,
  output logic                      avail_out,
  output logic                      req_out,
  input  logic                      avail_in,
  output logic [OUTPUT_WIDTH-1:0]   data_out,
  output logic [3:0]                num_flits_out,
  output logic                      BroadcastL2_VN0_out,
  output logic                      protocol_err,
  output logic [15:0]               err_count
);

  localparam int NUM_FLITS_MAX = (OUTPUT_WIDTH + FLIT_SIZE - 1) / FLIT_SIZE;
  localparam int PTR_W         = $clog2(NUM_FLITS_MAX + 1);
  localparam int BUF_W         = NUM_FLITS_MAX * FLIT_SIZE;

  localparam logic [FLIT_TYPE_SIZE-1:0] FLIT_HEADER      = FLIT_TYPE_SIZE'(0);
  localparam logic [FLIT_TYPE_SIZE-1:0] FLIT_PAYLOAD     = FLIT_TYPE_SIZE'(1);
  localparam logic [FLIT_TYPE_SIZE-1:0] FLIT_TAIL        = FLIT_TYPE_SIZE'(2);
  localparam logic [FLIT_TYPE_SIZE-1:0] FLIT_HEADER_TAIL = FLIT_TYPE_SIZE'(3);

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic               bcast_q, bcast_d;
  logic               err_q, err_d;
  logic               is_header;

  // Handshakes: a flit moves on req_in & avail_out, a message on req_out & avail_in.
  assign avail_out           = (state_q != HOLD);
  assign req_out             = (state_q == HOLD);
  assign data_out            = buf_q[OUTPUT_WIDTH-1:0];
  assign num_flits_out       = 4'(ptr_q);
  assign BroadcastL2_VN0_out = bcast_q;
  assign protocol_err        = err_q;
  assign is_header           = (data_type_in == FLIT_HEADER) || (data_type_in == FLIT_HEADER_TAIL);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    buf_d   = buf_q;
    bcast_d = bcast_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE, COLLECT: begin
        if (req_in) begin
          if (is_header) begin
            // A header always restarts assembly; one arriving mid-message is a framing error.
            err_d   = (state_q == COLLECT);
            buf_d   = '0;
            buf_d[FLIT_SIZE-1:0] = data_in;
            ptr_d   = PTR_W'(1);
            bcast_d = BroadcastL2_VN0_in;
            state_d = (data_type_in == FLIT_HEADER_TAIL) ? HOLD : COLLECT;
          end else if (state_q == IDLE) begin
            err_d = 1'b1;
          end else begin
            if (ptr_q < PTR_W'(NUM_FLITS_MAX)) begin
              for (int k = 0; k < NUM_FLITS_MAX; k++) begin
                if (ptr_q == PTR_W'(k)) buf_d[k*FLIT_SIZE +: FLIT_SIZE] = data_in;
              end
              ptr_d = ptr_q + PTR_W'(1);
            end else begin
              err_d = 1'b1;
            end
            if (data_type_in == FLIT_TAIL) state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (avail_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_p) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      buf_q   <= '0;
      bcast_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      buf_q   <= buf_d;
      bcast_q <= bcast_d;
      err_q   <= err_d;
    end
  end

`ifdef DESERIALIZER_NI_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  // Counts on the same edge that raises protocol_err, so the two stay aligned.
  always_ff @(posedge clk) begin
    if (rst_p) begin
      err_cnt_q <= '0;
    end else if (err_d && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_deserializer_ni.sv
// Directed bench for deserializer_ni: single-flit, multi-flit, back-pressure,
// framing error, overflow and mid-message reset scenarios.
module tb_deserializer_ni;

  localparam int FS = 64;
  localparam int TS = 2;
  localparam int OW = 256;

  localparam logic [1:0] T_H  = 2'd0;
  localparam logic [1:0] T_P  = 2'd1;
  localparam logic [1:0] T_T  = 2'd2;
  localparam logic [1:0] T_HT = 2'd3;

`ifdef DESERIALIZER_NI_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clk;
  logic          rst_p;
  logic          req_in;
  logic [FS-1:0] data_in;
  logic [TS-1:0] data_type_in;
  logic          bcast_in;
  logic          avail_out;
  logic          req_out;
  logic          avail_in;
  logic [OW-1:0] data_out;
  logic [3:0]    num_flits_out;
  logic          bcast_out;
  logic          protocol_err;
  logic [15:0]   err_count;

  int tests_run = 0;
  int tests_failed = 0;
  int err_seen = 0;
  int xfer_seen = 0;
  int err_base;
  int xfer_base;
  logic [OW-1:0] held;

  deserializer_ni #(.FLIT_SIZE(FS), .FLIT_TYPE_SIZE(TS), .OUTPUT_WIDTH(OW)) dut (
    .clk                 (clk),
    .rst_p               (rst_p),
    .req_in              (req_in),
    .data_in             (data_in),
    .data_type_in        (data_type_in),
    .BroadcastL2_VN0_in  (bcast_in),
    .avail_out           (avail_out),
    .req_out             (req_out),
    .avail_in            (avail_in),
    .data_out            (data_out),
    .num_flits_out       (num_flits_out),
    .BroadcastL2_VN0_out (bcast_out),
    .protocol_err        (protocol_err),
    .err_count           (err_count)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse/transfer monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (protocol_err) err_seen++;
    if (req_out && avail_in) xfer_seen++;
  end

  task automatic check_eq(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_flit(input logic [1:0] t, input logic [FS-1:0] d, input logic bc);
    req_in       = 1'b1;
    data_type_in = t;
    data_in      = d;
    bcast_in     = bc;
    step();
    req_in       = 1'b0;
    data_type_in = T_P;
    data_in      = '0;
    bcast_in     = 1'b0;
  endtask

  initial begin
    rst_p = 1'b1; req_in = 1'b0; data_in = '0; data_type_in = T_P; bcast_in = 1'b0; avail_in = 1'b1;
    step(); step();
    rst_p = 1'b0;
    check_eq("rst_req_out", OW'(req_out), OW'(0));
    check_eq("rst_data_out", data_out, '0);
    check_eq("rst_num_flits", OW'(num_flits_out), OW'(0));
    check_eq("rst_avail_out", OW'(avail_out), OW'(1));
    check_eq("rst_err", OW'(protocol_err), OW'(0));
    check_eq("rst_err_count", OW'(err_count), OW'(0));

    // 1: single header_tail
    drive_flit(T_HT, 64'hA5, 1'b0);
    check_eq("s1_req_out", OW'(req_out), OW'(1));
    check_eq("s1_data_out", data_out, OW'(64'hA5));
    check_eq("s1_num_flits", OW'(num_flits_out), OW'(1));
    step();
    check_eq("s1_req_out_drop", OW'(req_out), OW'(0));
    check_eq("s1_avail_back", OW'(avail_out), OW'(1));

    // 2: H,P,P,T with broadcast on header
    drive_flit(T_H, 64'h1, 1'b1);
    drive_flit(T_P, 64'h2, 1'b0);
    drive_flit(T_P, 64'h3, 1'b0);
    drive_flit(T_T, 64'h4, 1'b0);
    check_eq("s2_req_out", OW'(req_out), OW'(1));
    check_eq("s2_data_out", data_out, {64'h4, 64'h3, 64'h2, 64'h1});
    check_eq("s2_num_flits", OW'(num_flits_out), OW'(4));
    check_eq("s2_bcast", OW'(bcast_out), OW'(1));
    check_eq("s2_avail_low", OW'(avail_out), OW'(0));
    step();
    check_eq("s2_avail_high", OW'(avail_out), OW'(1));
    check_eq("s2_req_low", OW'(req_out), OW'(0));

    // 3: back-pressure while a header waits
    avail_in = 1'b0;
    drive_flit(T_H, 64'h5, 1'b0);
    drive_flit(T_P, 64'h6, 1'b0);
    drive_flit(T_P, 64'h7, 1'b0);
    drive_flit(T_T, 64'h8, 1'b0);
    held = {64'h8, 64'h7, 64'h6, 64'h5};
    xfer_base = xfer_seen;
    req_in = 1'b1; data_type_in = T_H; data_in = 64'hBB; bcast_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_eq("s3_req_hold", OW'(req_out), OW'(1));
      check_eq("s3_data_hold", data_out, held);
      check_eq("s3_avail_low", OW'(avail_out), OW'(0));
      step();
    end
    avail_in = 1'b1;
    step();
    check_eq("s3_req_after_xfer", OW'(req_out), OW'(0));
    check_eq("s3_data_before_hdr", data_out, held);
    step();
    req_in = 1'b0;
    check_eq("s3_one_xfer", OW'(xfer_seen - xfer_base), OW'(1));
    check_eq("s3_hdr_num", OW'(num_flits_out), OW'(1));
    check_eq("s3_hdr_data", data_out, OW'(64'hBB));
    drive_flit(T_T, 64'hCC, 1'b0);
    check_eq("s3_msg2_data", data_out, {128'h0, 64'hCC, 64'hBB});
    check_eq("s3_msg2_num", OW'(num_flits_out), OW'(2));
    step();

    // 4: header_tail interrupts a partial message
    err_base = err_seen;
    drive_flit(T_H, 64'h1, 1'b0);
    drive_flit(T_P, 64'h2, 1'b0);
    drive_flit(T_HT, 64'h7, 1'b0);
    check_eq("s4_req_out", OW'(req_out), OW'(1));
    check_eq("s4_data_out", data_out, OW'(64'h7));
    check_eq("s4_num_flits", OW'(num_flits_out), OW'(1));
    step();
    check_eq("s4_err_pulses", OW'(err_seen - err_base), OW'(1));
    check_eq("s4_err_count", OW'(err_count), CNT_EN ? OW'(1) : OW'(0));

    // 5: overflow past four slots
    err_base = err_seen;
    drive_flit(T_H, 64'h1, 1'b0);
    drive_flit(T_P, 64'h2, 1'b0);
    drive_flit(T_P, 64'h3, 1'b0);
    drive_flit(T_P, 64'h4, 1'b0);
    drive_flit(T_P, 64'h5, 1'b0);
    check_eq("s5_no_req_early", OW'(req_out), OW'(0));
    drive_flit(T_T, 64'h6, 1'b0);
    check_eq("s5_req_out", OW'(req_out), OW'(1));
    check_eq("s5_data_out", data_out, {64'h4, 64'h3, 64'h2, 64'h1});
    check_eq("s5_num_flits", OW'(num_flits_out), OW'(4));
    step();
    check_eq("s5_err_pulses", OW'(err_seen - err_base), OW'(2));
    check_eq("s5_err_count", OW'(err_count), CNT_EN ? OW'(3) : OW'(0));

    // 6: reset mid-message
    drive_flit(T_H, 64'h11, 1'b1);
    drive_flit(T_P, 64'h22, 1'b0);
    rst_p = 1'b1;
    step();
    rst_p = 1'b0;
    check_eq("s6_req_out", OW'(req_out), OW'(0));
    check_eq("s6_data_out", data_out, '0);
    check_eq("s6_num_flits", OW'(num_flits_out), OW'(0));
    check_eq("s6_bcast", OW'(bcast_out), OW'(0));
    check_eq("s6_err", OW'(protocol_err), OW'(0));
    check_eq("s6_err_count", OW'(err_count), OW'(0));
    check_eq("s6_avail_out", OW'(avail_out), OW'(1));
    err_base = err_seen;
    drive_flit(T_HT, 64'h9, 1'b0);
    check_eq("s6_req_after", OW'(req_out), OW'(1));
    check_eq("s6_data_after", data_out, OW'(64'h9));
    check_eq("s6_num_after", OW'(num_flits_out), OW'(1));
    step();
    check_eq("s6_no_err", OW'(err_seen - err_base), OW'(0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
